// File: rtl/zero_indices_sched.sv
// Round-robin scheduler that shares one zero-index engine among N requesters,
// forwarding each reported index with its owner id and a per-job completion count.
module zero_indices_sched #(
  parameter int N  = 4,
  parameter int W  = 128,
  parameter int IW = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_vector,
  output logic [N-1:0]         req_ready,
  output logic                 eng_start,
  output logic [W-1:0]         eng_vector,
  input  logic                 eng_busy_r,
  input  logic                 eng_resp_valid,
  input  logic [IW-1:0]        eng_resp_index,
  output logic                 out_valid_r,
  output logic [$clog2(N)-1:0] out_id_r,
  output logic [IW-1:0]        out_index_r,
  output logic                 done_valid_r,
  output logic [$clog2(N)-1:0] done_id_r,
  output logic [IW:0]          done_count_r,
  output logic                 spurious_r
);
  localparam int IDW = $clog2(N);
  localparam logic [IW:0] CNT_MAX = (IW+1)'(W);

  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   vec_q, vec_d;
  logic [IW:0]    count_q, count_d;
  logic           first_q, first_d;
  logic           out_valid_q, done_valid_q, spurious_q;
  logic [IDW-1:0] out_id_q, done_id_q;
  logic [IW-1:0]  out_index_q;
  logic [IW:0]    done_count_q;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx, cand;
  logic           resp_take;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  function automatic logic [IW:0] sat_inc(input logic [IW:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr, first hit wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    vec_d     = vec_q;
    count_d   = count_q;
    first_d   = 1'b0;
    req_ready = '0;
    resp_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          id_d     = gnt_idx;
          vec_d    = req_vector[int'(gnt_idx)*W +: W];
          count_d  = '0;
          rr_ptr_d = (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + 1'b1;
          state_d  = START;
        end
      end
      START: begin
        first_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        resp_take = eng_resp_valid;
        // Busy is not yet meaningful in the first cycle after the engine is started.
        if (!eng_busy_r && !first_q) state_d = DRAIN;
      end
      DRAIN: begin
        resp_take = eng_resp_valid;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (resp_take) count_d = sat_inc(count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      vec_q        <= '0;
      count_q      <= '0;
      first_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_index_q  <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_count_q <= '0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      vec_q        <= vec_d;
      count_q      <= count_d;
      first_q      <= first_d;
      out_valid_q  <= resp_take;
      if (resp_take) begin
        out_id_q    <= id_q;
        out_index_q <= eng_resp_index;
      end
      done_valid_q <= (state_q == DRAIN);
      if (state_q == DRAIN) begin
        done_id_q    <= id_q;
        done_count_q <= count_d;
      end
      if (eng_resp_valid && (state_q == IDLE || state_q == START)) spurious_q <= 1'b1;
    end
  end

  assign eng_start    = (state_q == START);
  assign eng_vector   = vec_q;
  assign out_valid_r  = out_valid_q;
  assign out_id_r     = out_id_q;
  assign out_index_r  = out_index_q;
  assign done_valid_r = done_valid_q;
  assign done_id_r    = done_id_q;
  assign done_count_r = done_count_q;
  assign spurious_r   = spurious_q;

endmodule

// File: tb/tb_zero_indices_sched.sv
// Bench for zero_indices_sched: behavioural engine, event monitor and per-scenario checks
// against expectations computed from the zero positions of each submitted vector.
module tb_zero_indices_sched;
  localparam int N  = 4;
  localparam int W  = 128;
  localparam int IW = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_vector;
  logic [N-1:0]   req_ready;
  logic           eng_start;
  logic [W-1:0]   eng_vector;
  logic           eng_busy_r;
  logic           eng_rv_e, force_rv;
  logic           eng_resp_valid;
  logic [IW-1:0]  eng_resp_index;
  logic           out_valid_r;
  logic [1:0]     out_id_r;
  logic [IW-1:0]  out_index_r;
  logic           done_valid_r;
  logic [1:0]     done_id_r;
  logic [IW:0]    done_count_r;
  logic           spurious_r;

  assign eng_resp_valid = eng_rv_e | force_rv;

  zero_indices_sched #(.N(N), .W(W), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_vector(req_vector),
    .req_ready(req_ready), .eng_start(eng_start), .eng_vector(eng_vector),
    .eng_busy_r(eng_busy_r), .eng_resp_valid(eng_resp_valid),
    .eng_resp_index(eng_resp_index), .out_valid_r(out_valid_r), .out_id_r(out_id_r),
    .out_index_r(out_index_r), .done_valid_r(done_valid_r), .done_id_r(done_id_r),
    .done_count_r(done_count_r), .spurious_r(spurious_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_bad = 0;
  int g_id[$], g_cyc[$], s_cyc[$], o_id[$], o_idx[$], o_cyc[$], d_id[$], d_cnt[$], d_cyc[$];
  int exp_q[$];
  bit eng_gaps = 0, eng_merge = 0, eng_late = 0;

  // Monitor: samples one time unit before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (req_ready != '0) begin
        if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0) ready_bad++;
        for (int i = 0; i < N; i++)
          if (req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
      end
      if (eng_start) s_cyc.push_back(cyc);
      if (out_valid_r) begin
        o_id.push_back(int'(out_id_r)); o_idx.push_back(int'(out_index_r)); o_cyc.push_back(cyc);
      end
      if (done_valid_r) begin
        d_id.push_back(int'(done_id_r)); d_cnt.push_back(int'(done_count_r)); d_cyc.push_back(cyc);
      end
    end
  end

  // Behavioural engine: reports zero positions in ascending order, one per busy cycle.
  task automatic run_engine();
    logic [W-1:0] v;
    int zl[$];
    bit sb[$], sv[$];
    int si[$];
    bit late, last;
    v = eng_vector;
    for (int b = 0; b < W; b++) if (!v[b]) zl.push_back(b);
    late = eng_late && (zl.size() > 0);
    for (int k = 0; k < zl.size(); k++) begin
      last = (k == zl.size() - 1);
      if (k > 0 && eng_gaps && $urandom_range(0, 2) == 0) begin
        sb.push_back(1); sv.push_back(0); si.push_back(0);
      end
      if (last && late) begin
        sb.push_back(1); sv.push_back(0); si.push_back(0);
        sb.push_back(0); sv.push_back(0); si.push_back(0);
        sb.push_back(0); sv.push_back(1); si.push_back(zl[k]);
      end else if (last && eng_merge) begin
        sb.push_back(0); sv.push_back(1); si.push_back(zl[k]);
      end else begin
        sb.push_back(1); sv.push_back(1); si.push_back(zl[k]);
        if (last) begin sb.push_back(0); sv.push_back(0); si.push_back(0); end
      end
    end
    if (zl.size() == 0) begin sb.push_back(0); sv.push_back(0); si.push_back(0); end
    for (int s = 0; s < sb.size(); s++) begin
      @(negedge clk);
      if (rst) begin eng_busy_r = 1'b0; eng_rv_e = 1'b0; return; end
      eng_busy_r = sb[s]; eng_rv_e = sv[s]; eng_resp_index = IW'(si[s]);
    end
  endtask

  initial begin
    eng_busy_r = 1'b0; eng_rv_e = 1'b0; eng_resp_index = '0;
    forever begin
      @(negedge clk);
      eng_busy_r = 1'b0; eng_rv_e = 1'b0;
      if (eng_start && !rst) run_engine();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void build_exp(input logic [W-1:0] v);
    exp_q.delete();
    for (int b = 0; b < W; b++) if (!v[b]) exp_q.push_back(b);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int j = p; j < N; j++) if (m[j]) return j;
    for (int j = 0; j < p; j++) if (m[j]) return j;
    return -1;
  endfunction

  function automatic logic [W-1:0] sparse_vec();
    logic [W-1:0] v;
    for (int w = 0; w < W / 32; w++) v[w*32 +: 32] = ~($urandom & $urandom & $urandom);
    return v;
  endfunction

  task automatic clear_log();
    g_id.delete(); g_cyc.delete(); s_cyc.delete(); o_id.delete(); o_idx.delete();
    o_cyc.delete(); d_id.delete(); d_cnt.delete(); d_cyc.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
  endtask

  task automatic do_job(input int id, input logic [W-1:0] v, output bit ok);
    int g0, d0, n;
    g0 = g_id.size(); d0 = d_id.size(); ok = 1'b0;
    @(negedge clk);
    req_vector[id*W +: W] = v;
    req_valid[id] = 1'b1;
    n = 0;
    while (g_id.size() == g0 && n < 50) begin @(negedge clk); n++; end
    req_valid[id] = 1'b0;
    if (g_id.size() == g0) return;
    n = 0;
    while (d_id.size() == d0 && n < 600) begin @(negedge clk); n++; end
    ok = (d_id.size() > d0);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_vector = '0; force_rv = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    checks++; if (eng_start !== 1'b0 || out_valid_r !== 1'b0 || done_valid_r !== 1'b0) begin
      errors++; $display("FAIL rst_pulses: got start=%b out=%b done=%b want 0", eng_start, out_valid_r, done_valid_r); end
    checks++; if (eng_vector !== '0) begin errors++; $display("FAIL rst_vector: got %h want 0", eng_vector); end
    checks++; if (out_id_r !== '0 || out_index_r !== '0 || done_id_r !== '0 || done_count_r !== '0) begin
      errors++; $display("FAIL rst_held: got %0d %0d %0d %0d want 0", out_id_r, out_index_r, done_id_r, done_count_r); end
    checks++; if (spurious_r !== 1'b0) begin errors++; $display("FAIL rst_spurious: got %b want 0", spurious_r); end
    @(negedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (eng_start !== 1'b0 || out_valid_r !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: got start=%b out=%b want 0", eng_start, out_valid_r); end
  endtask

  task automatic test_single();
    logic [W-1:0] v;
    bit ok;
    clear_log(); eng_gaps = 0; eng_merge = 0; eng_late = 0;
    v = '1; v[5] = 1'b0; v[70] = 1'b0;
    do_job(2, v, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got no done pulse want one"); end
    checks++; if (g_id.size() != 1 || g_id[0] != 2) begin errors++; $display("FAIL single_grant: got %0d grants want one to 2", g_id.size()); end
    if (ok) begin
      checks++; if (s_cyc.size() != 1 || s_cyc[0] != g_cyc[0] + 1) begin
        errors++; $display("FAIL single_start: got %0d starts want one at grant+1", s_cyc.size()); end
      checks++; if (o_idx.size() != 2 || o_idx[0] != 5 || o_idx[1] != 70 || o_id[0] != 2 || o_id[1] != 2) begin
        errors++; $display("FAIL single_out: got %0d pulses want idx 5,70 id 2", o_idx.size()); end
      checks++; if (o_cyc.size() == 0 || o_cyc[0] != g_cyc[0] + 3) begin
        errors++; $display("FAIL single_latency: got first out at cycle %0d want %0d", (o_cyc.size() > 0) ? o_cyc[0] : -1, g_cyc[0] + 3); end
      checks++; if (d_id[0] != 2 || d_cnt[0] != 2) begin
        errors++; $display("FAIL single_done_vals: got id %0d count %0d want 2 2", d_id[0], d_cnt[0]); end
    end
    checks++; if (eng_vector !== v) begin errors++; $display("FAIL single_vector: got %h want %h", eng_vector, v); end
    repeat (5) @(negedge clk);
    checks++; if (out_index_r !== 7'd70 || done_count_r !== 8'd2 || done_id_r !== 2'd2) begin
      errors++; $display("FAIL single_hold: got idx %0d cnt %0d id %0d want 70 2 2", out_index_r, done_count_r, done_id_r); end
    checks++; if (d_id.size() != 1 || done_valid_r !== 1'b0) begin
      errors++; $display("FAIL single_pulse: got %0d done pulses want 1", d_id.size()); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vecs [N];
    int all_exp[$], all_id[$];
    int rr_m, g, n;
    bit bad;
    pulse_reset();
    clear_log(); eng_gaps = 1; eng_merge = $urandom_range(0, 1); eng_late = 0;
    rr_m = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin vecs[i] = sparse_vec(); req_vector[i*W +: W] = vecs[i]; end
    req_valid = '1;
    n = 0;
    while (g_id.size() < 5 && n < 3000) begin @(negedge clk); n++; end
    req_valid = '0;
    n = 0;
    while (d_id.size() < 5 && n < 1000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    checks++; if (g_id.size() != 5 || d_id.size() != 5) begin
      errors++; $display("FAIL b2b_count: got %0d grants %0d dones want 5 5", g_id.size(), d_id.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        g = rr_pick('1, rr_m);
        rr_m = (g + 1) % N;
        build_exp(vecs[g]);
        foreach (exp_q[i]) begin all_exp.push_back(exp_q[i]); all_id.push_back(g); end
        checks++; if (g_id[k] != g || d_id[k] != g || d_cnt[k] != exp_q.size()) begin
          errors++; $display("FAIL b2b_job%0d: got grant %0d done %0d cnt %0d want %0d %0d %0d", k, g_id[k], d_id[k], d_cnt[k], g, g, exp_q.size()); end
        if (k > 0) begin
          checks++; if (g_cyc[k] != d_cyc[k-1]) begin
            errors++; $display("FAIL b2b_gap%0d: got grant cycle %0d want %0d", k, g_cyc[k], d_cyc[k-1]); end
        end
      end
      bad = (o_idx.size() != all_exp.size());
      for (int i = 0; i < o_idx.size() && !bad; i++) if (o_idx[i] != all_exp[i] || o_id[i] != all_id[i]) bad = 1;
      checks++; if (bad) begin errors++; $display("FAIL b2b_out: got %0d pulses want %0d with matching idx/id", o_idx.size(), all_exp.size()); end
    end
  endtask

  task automatic test_all_ones();
    bit ok;
    clear_log(); eng_gaps = 0; eng_merge = 0; eng_late = 0;
    do_job(1, '1, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok || o_idx.size() != 0) begin errors++; $display("FAIL ones_out: got done=%0b pulses %0d want 1 0", ok, o_idx.size()); end
    checks++; if (done_count_r !== '0 || done_id_r !== 2'd1) begin
      errors++; $display("FAIL ones_done: got cnt %0d id %0d want 0 1", done_count_r, done_id_r); end
  endtask

  task automatic test_all_zeros();
    bit ok;
    int bad;
    clear_log(); eng_gaps = 1; eng_merge = 0; eng_late = 0;
    do_job(3, '0, ok);
    bad = -1;
    for (int i = 0; i < o_idx.size(); i++) if ((o_idx[i] != i || o_id[i] != 3) && bad < 0) bad = i;
    checks++; if (!ok || o_idx.size() != W || bad != -1) begin
      errors++; $display("FAIL zeros_out: got %0d pulses first bad %0d want 128 in order", o_idx.size(), bad); end
    checks++; if (done_count_r !== 8'd128 || done_id_r !== 2'd3) begin
      errors++; $display("FAIL zeros_done: got cnt %0d id %0d want 128 3", done_count_r, done_id_r); end
  endtask

  task automatic test_drop();
    logic [W-1:0] v;
    bit ok;
    clear_log(); eng_gaps = 0; eng_merge = 0; eng_late = 0;
    v = '1; v[19:0] = '0;
    fork
      do_job(0, v, ok);
      begin
        repeat (6) @(negedge clk);
        req_valid[2] = 1'b1;
        repeat (3) @(negedge clk);
        req_valid[2] = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    checks++; if (!ok || g_id.size() != 1 || g_id[0] != 0) begin
      errors++; $display("FAIL drop_grant: got %0d grants want 1 to requester 0", g_id.size()); end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    bit ok, bad, chk_lat;
    int id;
    for (int j = 0; j < 12; j++) begin
      clear_log();
      id = $urandom_range(0, N - 1);
      v = sparse_vec();
      if (j == 0) begin v[0] = 1'b0; v[W-1] = 1'b0; end
      if (j == 5) begin v = '1; v[W-1] = 1'b0; end
      eng_gaps = $urandom_range(0, 1); eng_merge = (j % 3 == 1); eng_late = (j % 3 == 2);
      build_exp(v);
      do_job(id, v, ok);
      checks++; if (!ok || d_id[0] != id || d_cnt[0] != exp_q.size()) begin
        errors++; $display("FAIL rand_done%0d: got ok %0b id %0d cnt %0d want id %0d cnt %0d", j, ok, d_id[0], d_cnt[0], id, exp_q.size()); end
      bad = (o_idx.size() != exp_q.size());
      for (int i = 0; i < o_idx.size() && !bad; i++) if (o_idx[i] != exp_q[i] || o_id[i] != id) bad = 1;
      checks++; if (bad) begin errors++; $display("FAIL rand_out%0d: got %0d pulses want %0d with matching idx/id", j, o_idx.size(), exp_q.size()); end
      chk_lat = (exp_q.size() > 1) || (exp_q.size() == 1 && !eng_late);
      if (chk_lat && ok) begin
        checks++; if (o_cyc.size() == 0 || o_cyc[0] != g_cyc[0] + 3) begin
          errors++; $display("FAIL rand_latency%0d: got first out %0d want %0d", j, (o_cyc.size() > 0) ? o_cyc[0] : -1, g_cyc[0] + 3); end
      end
    end
    checks++; if (spurious_r !== 1'b0 || ready_bad != 0) begin
      errors++; $display("FAIL rand_clean: got spurious %b ready_bad %0d want 0 0", spurious_r, ready_bad); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v;
    bit ok;
    int n;
    clear_log(); eng_gaps = 0; eng_merge = 0; eng_late = 0;
    v = '1; v[9:0] = '0;
    @(negedge clk);
    req_vector[0 +: W] = v; req_valid[0] = 1'b1;
    n = 0;
    while (g_id.size() == 0 && n < 50) begin @(negedge clk); n++; end
    req_valid[0] = 1'b0;
    n = 0;
    while (o_idx.size() < 3 && n < 50) begin @(negedge clk); n++; end
    checks++; if (o_idx.size() < 3) begin errors++; $display("FAIL mid_progress: got %0d pulses want >=3", o_idx.size()); end
    #1 rst = 1'b1;
    #2;
    checks++; if (out_valid_r !== 1'b0 || out_index_r !== '0 || out_id_r !== '0 || eng_vector !== '0 || eng_start !== 1'b0) begin
      errors++; $display("FAIL mid_async: got out %b idx %0d vec %h want 0", out_valid_r, out_index_r, eng_vector); end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (d_id.size() != 0 || done_count_r !== '0 || done_id_r !== '0) begin
      errors++; $display("FAIL mid_nodone: got %0d done pulses cnt %0d want 0", d_id.size(), done_count_r); end
    clear_log();
    v = '1; v[100] = 1'b0; v[101] = 1'b0;
    do_job(3, v, ok);
    checks++; if (!ok || d_cnt[0] != 2 || d_id[0] != 3 || o_idx.size() != 2 || o_idx[0] != 100 || o_idx[1] != 101) begin
      errors++; $display("FAIL mid_fresh: got cnt %0d id %0d pulses %0d want 2 3 2", d_cnt[0], d_id[0], o_idx.size()); end
  endtask

  task automatic test_spurious();
    logic [W-1:0] v;
    bit ok;
    clear_log();
    repeat (2) @(negedge clk);
    force_rv = 1'b1;
    @(negedge clk);
    force_rv = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (spurious_r !== 1'b1 || o_idx.size() != 0) begin
      errors++; $display("FAIL spur_set: got spurious %b pulses %0d want 1 0", spurious_r, o_idx.size()); end
    v = '1; v[33] = 1'b0;
    do_job(0, v, ok);
    checks++; if (!ok || spurious_r !== 1'b1 || d_cnt[0] != 1) begin
      errors++; $display("FAIL spur_sticky: got spurious %b cnt %0d want 1 1", spurious_r, d_cnt[0]); end
    pulse_reset();
    #2;
    checks++; if (spurious_r !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b want 0", spurious_r); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_all_ones();
    test_all_zeros();
    test_drop();
    test_random();
    test_reset_mid();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zero_indices_sched.md
ZERO_INDICES_SCHED -- requirements
Module: zero_indices_sched

Interface
- REQ-001: Parameter N, default 4: number of requesters; 2..16.
- REQ-002: Parameter W, default 128: vector width; the attached zero-index engine has the same width.
- REQ-003: Parameter IW, default 7: index width, equal to $clog2(W).
- REQ-004: clk  in  1  single clock; all state updates on its rising edge.
- REQ-005: rst  in  1  reset, asynchronous, active-high.
- REQ-006: req_valid  in  N  per-requester request pending.
- REQ-007: req_vector  in  N*W  per-requester vector; slice i is bits [i*W +: W].
- REQ-008: req_ready  out  N  one-hot accept strobe, combinational.
- REQ-009: eng_start  out  1  single-cycle engine load/start.
- REQ-010: eng_vector  out  W  latched vector driven to the engine.
- REQ-011: eng_busy_r  in  1  engine busy flag.
- REQ-012: eng_resp_valid  in  1  engine zero-index strobe.
- REQ-013: eng_resp_index  in  IW  engine zero index.
- REQ-014: out_valid_r  out  1  forwarded index valid.
- REQ-015: out_id_r  out  $clog2(N)  owner of the forwarded index.
- REQ-016: out_index_r  out  IW  forwarded zero index.
- REQ-017: done_valid_r  out  1  job-complete pulse.
- REQ-018: done_id_r  out  $clog2(N)  owner of the completed job.
- REQ-019: done_count_r  out  IW+1  number of zeros reported for the job.
- REQ-020: spurious_r  out  1  sticky flag: engine response seen while no job is active.

Function
- REQ-021: FSM states are IDLE, START, RUN and DRAIN.
- REQ-022: IDLE: if any req_valid is set, the block raises req_ready[g] for the granted g in the same cycle, latches req_vector slice g and g, clears the count, and moves to START.
- REQ-023: Arbitration is round-robin. Grant goes to the lowest index >= rr_ptr with req_valid set, wrapping past N-1 to 0.
- REQ-024: After a grant to g, rr_ptr updates to (g+1) mod N. rr_ptr is 0 after reset.
- REQ-025: req_ready is zero in every state other than IDLE, and is zero in IDLE when no req_valid is set.
- REQ-026: START: eng_start is 1 for exactly one cycle; next state is RUN.
- REQ-027: eng_vector holds the latched vector from the grant until the next grant.
- REQ-028: RUN: each cycle with eng_resp_valid=1, the next cycle shows out_valid_r=1 with out_index_r=eng_resp_index and out_id_r=latched id, and the count increments.
- REQ-029: RUN exits to DRAIN on the first cycle with eng_busy_r=0 that is not the cycle immediately after START.
- REQ-030: DRAIN lasts one cycle. It forwards and counts eng_resp_valid as in RUN.
- REQ-031: DRAIN sets done_valid_r=1 in the next cycle, with done_id_r=latched id and done_count_r=final count (including any DRAIN response), then returns to IDLE.
- REQ-032: A grant is allowed in the IDLE cycle that directly follows DRAIN (back-to-back jobs).
- REQ-033: out_valid_r and done_valid_r are single-cycle pulses.
- REQ-034: out_index_r, out_id_r, done_id_r and done_count_r hold their values between pulses.
- REQ-035: The count saturates at W. An all-ones vector yields done_count_r=0 and no out_valid_r pulses.
- REQ-036: eng_resp_valid in IDLE or START is not forwarded and sets spurious_r. spurious_r clears only on reset.
- REQ-037: A requester that drops req_valid before being granted is never granted. Requests are not queued internally.
- REQ-038: Per-request latency: grant in cycle T, eng_start in T+1, first possible out_valid_r in T+3.

Reset
- REQ-039: On rst assertion, asynchronously: state=IDLE, rr_ptr=0, count=0, and eng_start, out_valid_r, done_valid_r and spurious_r are 0; latched id, index and count outputs are 0; eng_vector is 0.
- REQ-040: Reset mid-job abandons the job. No done pulse is issued and the engine is re-sequenced only by a new grant.

Verification
- REQ-041: N=4, only requester 2 valid, vector with zeros at bits 5 and 70 (all other bits 1) -> one grant to 2, eng_start one cycle later, out pulses with index 5 then 70 and id 2, then done_id_r=2 and done_count_r=2.
- REQ-042: All four requesters held valid after reset -> grants in order 0,1,2,3,0, back-to-back, with rr_ptr wrapping.
- REQ-043: All-ones vector from requester 1 -> no out_valid_r, done_count_r=0, done_id_r=1.
- REQ-044: All-zeros vector -> 128 out pulses with indices 0..127 and done_count_r=128.
- REQ-045: rst asserted during RUN after 3 responses -> no done pulse, all outputs 0; the next request completes normally with a fresh count.
- REQ-046: eng_resp_valid forced high in IDLE -> spurious_r=1 and no out_valid_r; spurious_r stays 1 until rst.
